adsr_envelope_gen: RTL and testbench



---
 rtl/adsr_pkg.sv | 24 ++
 rtl/adsr_envelope_gen_if.sv | 25 ++
 rtl/adsr_rate_timer.sv | 42 ++++
 rtl/adsr_envelope_gen.sv | 148 ++++++++++++++
 tb/tb_adsr_envelope_gen.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/adsr_pkg.sv
// Shared state encoding, level limits and saturating level arithmetic for the
// ADSR envelope generator.
package adsr_pkg;

    typedef logic [2:0] adsr_state_t;

    localparam adsr_state_t ST_IDLE    = 3'd0;
    localparam adsr_state_t ST_ATTACK  = 3'd1;
    localparam adsr_state_t ST_DECAY   = 3'd2;
    localparam adsr_state_t ST_SUSTAIN = 3'd3;
    localparam adsr_state_t ST_RELEASE = 3'd4;

    localparam logic [7:0] ENV_MAX = 8'hFF;
    localparam logic [7:0] ENV_MIN = 8'h00;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == ENV_MAX) ? ENV_MAX : v + 8'd1;
    endfunction

    function automatic logic [7:0] floor_sub(input logic [7:0] v, input logic [7:0] amt);
        return (v > amt) ? v - amt : ENV_MIN;
    endfunction

endpackage

// File: rtl/adsr_envelope_gen_if.sv
// Control/level bundle between the register file, the envelope generator and
// the amplitude modulator. master drives the controls, slave produces the envelope.
interface adsr_envelope_gen_if #(
    parameter int RATE_W = 8
);
    logic              sample_tick;
    logic              gate;
    logic [RATE_W-1:0] attack_rate;
    logic [RATE_W-1:0] decay_rate;
    logic [7:0]        sustain_level;
    logic [RATE_W-1:0] release_rate;
    logic [7:0]        envelope_value;
    logic [2:0]        env_state;
    logic              env_active;

    modport master (
        output sample_tick, gate, attack_rate, decay_rate, sustain_level, release_rate,
        input  envelope_value, env_state, env_active
    );

    modport slave (
        input  sample_tick, gate, attack_rate, decay_rate, sustain_level, release_rate,
        output envelope_value, env_state, env_active
    );
endinterface

// File: rtl/adsr_rate_timer.sv
// Sample-tick step timer: fires one step every (rate+1) << RATE_SHIFT ticks.
// clear_i restarts the period (used on every envelope state change).
module adsr_rate_timer #(
    parameter int RATE_W     = 8,
    parameter int RATE_SHIFT = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick_i,
    input  logic              clear_i,
    input  logic [RATE_W-1:0] rate_i,
    output logic              step_o
);
    localparam int CW = RATE_W + RATE_SHIFT;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] terminal;
    logic          at_term;

    // ((rate+1) << S) - 1 == (rate << S) | ((1 << S) - 1), which never overflows CW bits
    assign terminal = (CW'(rate_i) << RATE_SHIFT) | CW'((1 << RATE_SHIFT) - 1);
    assign at_term  = (cnt_q == terminal);
    assign step_o   = tick_i & at_term;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (tick_i) begin
            cnt_d = at_term ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/adsr_envelope_gen.sv
// ADSR envelope generator: gate-driven five-state sequencer stepping an 8-bit level.
// Build option ADSR_EXP_DECAY_EN selects max(1, env>>3) decay/release steps.
//
// state      | meaning
// -----------+--------------------------------------------------------
// ST_IDLE    | no note; level held at 0
// ST_ATTACK  | level rises by 1 per step until 0xFF
// ST_DECAY   | level falls per step until it reaches sustain_level
// ST_SUSTAIN | level follows sustain_level live while gate held
// ST_RELEASE | level falls per step until 0, then back to idle
module adsr_envelope_gen
    import adsr_pkg::*;
#(
    parameter int RATE_W     = 8,
    parameter int RATE_SHIFT = 0
) (
    input  logic                clk,
    input  logic                rst,
    adsr_envelope_gen_if.slave  env_if
);

    adsr_state_t       state_q, state_d;
    logic [7:0]        env_q, env_d;
    logic              gate_q;
    logic              rise, fall;
    logic              step;
    logic              timer_clear;
    logic [RATE_W-1:0] rate_sel;
    logic [7:0]        dec_amt;
    logic [7:0]        dec_val;
    logic [7:0]        inc_val;

    assign rise = env_if.gate & ~gate_q;
    assign fall = ~env_if.gate & gate_q;

    always_comb begin
        case (state_q)
            ST_ATTACK:  rate_sel = env_if.attack_rate;
            ST_DECAY:   rate_sel = env_if.decay_rate;
            ST_RELEASE: rate_sel = env_if.release_rate;
            default:    rate_sel = '0;
        endcase
    end

`ifdef ADSR_EXP_DECAY_EN
    assign dec_amt = (env_q[7:3] == 5'd0) ? 8'd1 : {3'b000, env_q[7:3]};
`else
    assign dec_amt = 8'd1;
`endif

    assign dec_val = floor_sub(env_q, dec_amt);
    assign inc_val = sat_inc(env_q);

    assign timer_clear = (state_d != state_q);

    adsr_rate_timer #(
        .RATE_W     (RATE_W),
        .RATE_SHIFT (RATE_SHIFT)
    ) u_rate_timer (
        .clk     (clk),
        .rst     (rst),
        .tick_i  (env_if.sample_tick),
        .clear_i (timer_clear),
        .rate_i  (rate_sel),
        .step_o  (step)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            env_q   <= ENV_MIN;
            gate_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            env_q   <= env_d;
            gate_q  <= env_if.gate;
        end
    end

    // Gate edges are tested first so they pre-empt level targets and discard a coincident step.
    always_comb begin
        state_d = state_q;
        env_d   = env_q;
        case (state_q)
            ST_IDLE: begin
                env_d = ENV_MIN;
                if (rise) state_d = ST_ATTACK;
            end
            ST_ATTACK: begin
                if (fall) begin
                    state_d = ST_RELEASE;
                end else if (env_q == ENV_MAX) begin
                    state_d = ST_DECAY;
                end else if (step) begin
                    env_d = inc_val;
                    if (inc_val == ENV_MAX) state_d = ST_DECAY;
                end
            end
            ST_DECAY: begin
                if (fall) begin
                    state_d = ST_RELEASE;
                end else if (rise) begin
                    state_d = ST_ATTACK;
                end else if (env_q <= env_if.sustain_level) begin
                    state_d = ST_SUSTAIN;
                    env_d   = env_if.sustain_level;
                end else if (step) begin
                    if (dec_val <= env_if.sustain_level) begin
                        state_d = ST_SUSTAIN;
                        env_d   = env_if.sustain_level;
                    end else begin
                        env_d = dec_val;
                    end
                end
            end
            ST_SUSTAIN: begin
                if (fall) begin
                    state_d = ST_RELEASE;
                end else if (rise) begin
                    state_d = ST_ATTACK;
                end else begin
                    env_d = env_if.sustain_level;
                end
            end
            ST_RELEASE: begin
                if (rise) begin
                    state_d = ST_ATTACK;
                end else if (env_q == ENV_MIN) begin
                    state_d = ST_IDLE;
                end else if (step) begin
                    env_d = dec_val;
                    if (dec_val == ENV_MIN) state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                env_d   = ENV_MIN;
            end
        endcase
    end

    always_comb begin
        env_if.envelope_value = env_q;
        env_if.env_state      = state_q;
        env_if.env_active     = (state_q != ST_IDLE);
    end

endmodule

// File: tb/tb_adsr_envelope_gen.sv
// Bench for adsr_envelope_gen: directed note scenarios plus randomized gate/tick
// traffic, all checked against a cycle-level behavioural envelope model.
module tb_adsr_envelope_gen;

    localparam int RW    = 8;
    localparam int P_IDLE = 0, P_ATK = 1, P_DEC = 2, P_SUS = 3, P_REL = 4;
`ifdef ADSR_EXP_DECAY_EN
    localparam int T3_LOW  = 30;    // 64,56,49,43,38,34,30
    localparam int T5_DEC  = 8'hAC; // 255,224,196,172
    localparam int REL_1   = 8'hE0;
    localparam int REL_2   = 8'hC4;
`else
    localparam int T3_LOW  = 8'h20;
    localparam int T5_DEC  = 8'hA0;
    localparam int REL_1   = 8'hFE;
    localparam int REL_2   = 8'hFD;
`endif

    logic clk = 1'b0;
    logic rst;

    adsr_envelope_gen_if #(.RATE_W(RW)) env_if ();

    adsr_envelope_gen #(.RATE_W(RW), .RATE_SHIFT(0)) dut (
        .clk    (clk),
        .rst    (rst),
        .env_if (env_if.slave)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    int m_phase, m_env, m_ticks;
    bit m_prev;

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", tag, got, got, exp, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = P_IDLE;
        m_env   = 0;
        m_ticks = 0;
        m_prev  = 1'b0;
    endtask

    function automatic int step_down(input int lvl);
        int amt;
`ifdef ADSR_EXP_DECAY_EN
        amt = lvl / 8;
        if (amt < 1) amt = 1;
`else
        amt = 1;
`endif
        return (lvl - amt < 0) ? 0 : lvl - amt;
    endfunction

    // Evaluated at each rising clock edge with the inputs that edge samples.
    task automatic model_edge();
        bit rise, fall, stepped;
        int period, nxt, sus;
        if (rst) begin
            model_reset();
            return;
        end
        rise   = env_if.gate && !m_prev;
        fall   = !env_if.gate && m_prev;
        m_prev = env_if.gate;
        sus    = int'(env_if.sustain_level);
        case (m_phase)
            P_ATK:   period = int'(env_if.attack_rate) + 1;
            P_DEC:   period = int'(env_if.decay_rate) + 1;
            P_REL:   period = int'(env_if.release_rate) + 1;
            default: period = 1;
        endcase
        stepped = 1'b0;
        if (env_if.sample_tick) begin
            m_ticks++;
            stepped = (m_ticks % period) == 0;
        end
        nxt = m_phase;
        if (rise) begin
            nxt = P_ATK;
        end else if (fall && (m_phase == P_ATK || m_phase == P_DEC || m_phase == P_SUS)) begin
            nxt = P_REL;
        end else if (m_phase == P_IDLE) begin
            m_env = 0;
        end else if (m_phase == P_ATK) begin
            if (m_env == 255) nxt = P_DEC;
            else if (stepped) begin
                m_env = m_env + 1;
                if (m_env == 255) nxt = P_DEC;
            end
        end else if (m_phase == P_DEC) begin
            if (m_env <= sus) begin
                m_env = sus;
                nxt   = P_SUS;
            end else if (stepped) begin
                m_env = step_down(m_env);
                if (m_env <= sus) begin
                    m_env = sus;
                    nxt   = P_SUS;
                end
            end
        end else if (m_phase == P_SUS) begin
            m_env = sus;
        end else begin
            if (m_env == 0) nxt = P_IDLE;
            else if (stepped) begin
                m_env = step_down(m_env);
                if (m_env == 0) nxt = P_IDLE;
            end
        end
        if (nxt != m_phase) m_ticks = 0;
        m_phase = nxt;
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("model_env", int'(env_if.envelope_value), m_env);
        chk("model_state", int'(env_if.env_state), m_phase);
        chk("model_active", int'(env_if.env_active), int'(m_phase != P_IDLE));
    endtask

    task automatic count_state(input int s, input int budget, output int n);
        n = 0;
        while (int'(env_if.env_state) == s && n < budget) begin
            n++;
            cyc();
        end
    endtask

    task automatic run_until_le(input int lvl, input int budget);
        int n;
        n = 0;
        while (int'(env_if.envelope_value) > lvl && n < budget) begin
            n++;
            cyc();
        end
    endtask

    initial begin
        int n, hold;
        rst                  = 1'b1;
        env_if.gate          = 1'b0;
        env_if.sample_tick   = 1'b0;
        env_if.attack_rate   = '0;
        env_if.decay_rate    = '0;
        env_if.release_rate  = '0;
        env_if.sustain_level = 8'h80;
        model_reset();
        cyc();
        cyc();
        chk("rst_env", int'(env_if.envelope_value), 0);
        chk("rst_state", int'(env_if.env_state), P_IDLE);
        chk("rst_active", int'(env_if.env_active), 0);
        rst = 1'b0;

        // full note at rate 0, sustain 0x80
        env_if.sample_tick = 1'b1;
        env_if.gate        = 1'b1;
        cyc();
        chk("t1_enter_attack", int'(env_if.env_state), P_ATK);
        chk("t1_attack_start", int'(env_if.envelope_value), 0);
        count_state(P_ATK, 400, n);
        chk("t1_attack_ticks", n, 255);
        chk("t1_decay_state", int'(env_if.env_state), P_DEC);
        chk("t1_peak", int'(env_if.envelope_value), 255);
        count_state(P_DEC, 400, n);
`ifndef ADSR_EXP_DECAY_EN
        chk("t1_decay_ticks", n, 127);
`endif
        chk("t1_sus_state", int'(env_if.env_state), P_SUS);
        chk("t1_sus_env", int'(env_if.envelope_value), 8'h80);
        env_if.gate = 1'b0;
        cyc();
        chk("t1_rel_state", int'(env_if.env_state), P_REL);
        chk("t1_rel_start", int'(env_if.envelope_value), 8'h80);
        count_state(P_REL, 400, n);
`ifndef ADSR_EXP_DECAY_EN
        chk("t1_rel_ticks", n, 128);
`endif
        chk("t1_idle_state", int'(env_if.env_state), P_IDLE);
        chk("t1_idle_env", int'(env_if.envelope_value), 0);
        chk("t1_idle_active", int'(env_if.env_active), 0);

        // attack_rate 3 with gapped ticks: one step per 4 ticks
        env_if.attack_rate = 8'd3;
        env_if.sample_tick = 1'b0;
        env_if.gate        = 1'b1;
        cyc();
        for (int k = 1; k <= 40; k++) begin
            for (int g = $urandom_range(0, 2); g > 0; g--) cyc();
            env_if.sample_tick = 1'b1;
            cyc();
            env_if.sample_tick = 1'b0;
            chk("t2_env_per_tick", int'(env_if.envelope_value), k / 4);
        end
        env_if.gate        = 1'b0;
        env_if.sample_tick = 1'b1;
        cyc();
        count_state(P_REL, 400, n);
        chk("t2_back_idle", int'(env_if.env_state), P_IDLE);
        env_if.attack_rate = '0;

        // gate drop mid-attack, then retrigger during release
        env_if.gate = 1'b1;
        cyc();
        run_until_le(-1, 0);
        n = 0;
        while (int'(env_if.envelope_value) != 8'h40 && n < 300) begin
            n++;
            cyc();
        end
        chk("t3_reach_40", int'(env_if.envelope_value), 8'h40);
        env_if.gate = 1'b0;
        cyc();
        chk("t3_rel_state", int'(env_if.env_state), P_REL);
        chk("t3_rel_hold", int'(env_if.envelope_value), 8'h40);
        run_until_le(T3_LOW, 300);
        chk("t3_rel_low", int'(env_if.envelope_value), T3_LOW);
        env_if.gate = 1'b1;
        cyc();
        chk("t3_retrig_state", int'(env_if.env_state), P_ATK);
        chk("t3_retrig_env", int'(env_if.envelope_value), T3_LOW);
        cyc();
        chk("t3_retrig_inc", int'(env_if.envelope_value), T3_LOW + 1);

        // sustain 0xFF: one-cycle decay; live sustain changes
        env_if.sustain_level = 8'hFF;
        count_state(P_ATK, 400, n);
        chk("t4_decay_state", int'(env_if.env_state), P_DEC);
        chk("t4_decay_env", int'(env_if.envelope_value), 255);
        cyc();
        chk("t4_sus_state", int'(env_if.env_state), P_SUS);
        chk("t4_sus_env", int'(env_if.envelope_value), 255);
        env_if.sustain_level = 8'h10;
        cyc();
        chk("t4_sus_track", int'(env_if.envelope_value), 8'h10);
        env_if.sustain_level = 8'h00;
        cyc();
        chk("t4_sus_zero_env", int'(env_if.envelope_value), 0);
        chk("t4_sus_zero_state", int'(env_if.env_state), P_SUS);
        env_if.sustain_level = 8'hFF;
        cyc();
        env_if.gate = 1'b0;
        cyc();
        chk("t4_rel_from_ff", int'(env_if.envelope_value), 255);
        cyc();
        chk("t4_rel_step1", int'(env_if.envelope_value), REL_1);
        cyc();
        chk("t4_rel_step2", int'(env_if.envelope_value), REL_2);
        count_state(P_REL, 400, n);
        chk("t4_idle", int'(env_if.env_state), P_IDLE);

        // async reset in decay, then held gate retriggers on the first clock
        env_if.sustain_level = 8'h50;
        env_if.gate          = 1'b1;
        cyc();
        n = 0;
        while (!(int'(env_if.env_state) == P_DEC && int'(env_if.envelope_value) == T5_DEC) && n < 600) begin
            n++;
            cyc();
        end
        chk("t5_reach_decay", int'(env_if.envelope_value), T5_DEC);
        rst = 1'b1;
        #1;
        model_reset();
        chk("t5_async_env", int'(env_if.envelope_value), 0);
        chk("t5_async_state", int'(env_if.env_state), P_IDLE);
        chk("t5_async_active", int'(env_if.env_active), 0);
        cyc();
        rst = 1'b0;
        cyc();
        chk("t5_restart_state", int'(env_if.env_state), P_ATK);
        chk("t5_restart_env", int'(env_if.envelope_value), 0);
        count_state(P_ATK, 400, n);
        count_state(P_DEC, 400, n);
        chk("t5_sus_floor", int'(env_if.envelope_value), 8'h50);
        env_if.gate = 1'b0;
        cyc();
        count_state(P_REL, 400, n);

        // randomized traffic; rates only change while idle
        hold = 0;
        for (int i = 0; i < 6000; i++) begin
            if (hold == 0) begin
                env_if.gate = ~env_if.gate;
                hold = $urandom_range(1, 400);
            end
            hold--;
            env_if.sample_tick = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 99) == 0) env_if.sustain_level = 8'($urandom_range(0, 255));
            if (m_phase == P_IDLE) begin
                env_if.attack_rate  = 8'($urandom_range(0, 2));
                env_if.decay_rate   = 8'($urandom_range(0, 2));
                env_if.release_rate = 8'($urandom_range(0, 2));
            end
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
